// File: rtl/game_pkg.sv
// Shared types and constants for the game timer and its neighbours.
package game_pkg;

    typedef logic [1:0][3:0] bcd2_t;

    localparam bcd2_t       BCD_MAX                = 8'h99;
    localparam int unsigned FRAMES_PER_SEC_DEFAULT = 30;

    typedef enum logic {
        RUNNING,
        EXPIRED
    } timer_state_e;

endpackage

// File: rtl/game_timer_if.sv
// Frame pacing, bonus request and timer status bundle between controller and game_timer.
interface game_timer_if;
    import game_pkg::*;

    logic  startOfFrame;
    logic  run;
    logic  add_time;
    bcd2_t time_to_add;
    bcd2_t time_digits;
    logic  out_of_time;
    logic  low_time;
    logic  blink;

    modport master (
        output startOfFrame, run, add_time, time_to_add,
        input  time_digits, out_of_time, low_time, blink
    );

    modport slave (
        input  startOfFrame, run, add_time, time_to_add,
        output time_digits, out_of_time, low_time, blink
    );

endinterface

// File: rtl/bcd2_add_sat.sv
// Two-digit BCD: optional decrement by one, then add of a digit-clamped bonus, saturating at 99.
module bcd2_add_sat
    import game_pkg::*;
(
    input  bcd2_t value_i,
    input  logic  dec_i,
    input  logic  add_i,
    input  bcd2_t bonus_i,
    output bcd2_t sum_o,
    output logic  zero_o
);

    logic [3:0] a_u, a_t, b_u, b_t;
    logic [4:0] u_sum, t_sum;
    logic       carry;

    always_comb begin
        a_u = value_i[0];
        a_t = value_i[1];
        // Decrement floors at 00 so the adder never wraps to 99 on a stray tick.
        if (dec_i && (value_i != '0)) begin
            if (value_i[0] == 4'd0) begin
                a_u = 4'd9;
                a_t = value_i[1] - 4'd1;
            end else begin
                a_u = value_i[0] - 4'd1;
            end
        end

        b_u = '0;
        b_t = '0;
        if (add_i) begin
            b_u = (bonus_i[0] > 4'd9) ? 4'd9 : bonus_i[0];
            b_t = (bonus_i[1] > 4'd9) ? 4'd9 : bonus_i[1];
        end

        u_sum = {1'b0, a_u} + {1'b0, b_u};
        carry = (u_sum > 5'd9);
        if (carry) begin
            u_sum = u_sum - 5'd10;
        end
        t_sum = {1'b0, a_t} + {1'b0, b_t} + {4'b0, carry};

        if (t_sum > 5'd9) begin
            sum_o = BCD_MAX;
        end else begin
            sum_o = {t_sum[3:0], u_sum[3:0]};
        end
        zero_o = (sum_o == '0);
    end

endmodule

// File: rtl/game_timer.sv
// Two-digit BCD play-time countdown paced by startOfFrame, with bonus adds and a sticky expiry.
// Optional low-time warning/blink outputs are built when GAME_TIMER_WARNING_EN is defined.
module game_timer
    import game_pkg::*;
#(
    parameter bcd2_t       START_TIME     = BCD_MAX,
    parameter int unsigned FRAMES_PER_SEC = FRAMES_PER_SEC_DEFAULT,
    parameter bcd2_t       LOW_THRESHOLD  = 8'h10,
    parameter int unsigned BLINK_FRAMES   = 15
) (
    input  logic        clk,
    input  logic        resetN,
    game_timer_if.slave tif
);

    localparam int unsigned   PW         = (FRAMES_PER_SEC > 1) ? $clog2(FRAMES_PER_SEC) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(FRAMES_PER_SEC - 1);

    if ((FRAMES_PER_SEC < 1) || (BLINK_FRAMES < 1) || (LOW_THRESHOLD > BCD_MAX)) begin : g_param_check
        $error("game_timer: invalid parameter set");
    end

    timer_state_e  state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    bcd2_t         time_q, time_d;
    bcd2_t         sum;
    logic          sum_zero;
    logic          running;
    logic          tick;
    logic          upd;
    logic          out_of_time;

    assign running = (state_q == RUNNING);
    assign tick    = running && tif.run && tif.startOfFrame && (presc_q == PRESC_LAST);
    assign upd     = running && (tick || tif.add_time);

    bcd2_add_sat u_add (
        .value_i (time_q),
        .dec_i   (tick),
        .add_i   (tif.add_time),
        .bonus_i (tif.time_to_add),
        .sum_o   (sum),
        .zero_o  (sum_zero)
    );

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q <= RUNNING;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUNNING: if (upd && sum_zero) state_d = EXPIRED;
            EXPIRED: state_d = EXPIRED;
        endcase
    end

    always_comb begin
        out_of_time = (state_q == EXPIRED);
    end

    always_comb begin
        presc_d = presc_q;
        time_d  = time_q;
        if (running && tif.run && tif.startOfFrame) begin
            presc_d = (presc_q == PRESC_LAST) ? '0 : presc_q + PW'(1);
        end
        if (upd) begin
            time_d = sum;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            presc_q <= '0;
            time_q  <= START_TIME;
        end else begin
            presc_q <= presc_d;
            time_q  <= time_d;
        end
    end

    assign tif.time_digits = time_q;
    assign tif.out_of_time = out_of_time;

`ifdef GAME_TIMER_WARNING_EN
    localparam int unsigned   BW         = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

    logic          low_q, low_d;
    logic          blink_q, blink_d;
    logic [BW-1:0] bcnt_q, bcnt_d;

    // Judged on next-state values so the warning edge lines up with the digit change.
    assign low_d = (state_d == RUNNING) && (time_d <= LOW_THRESHOLD);

    always_comb begin
        bcnt_d  = bcnt_q;
        blink_d = blink_q;
        if (!low_d) begin
            bcnt_d  = '0;
            blink_d = 1'b0;
        end else if (low_q && tif.startOfFrame) begin
            if (bcnt_q == BLINK_LAST) begin
                bcnt_d  = '0;
                blink_d = ~blink_q;
            end else begin
                bcnt_d = bcnt_q + BW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            low_q   <= 1'b0;
            blink_q <= 1'b0;
            bcnt_q  <= '0;
        end else begin
            low_q   <= low_d;
            blink_q <= blink_d;
            bcnt_q  <= bcnt_d;
        end
    end

    assign tif.low_time = low_q;
    assign tif.blink    = blink_q;
`else
    assign tif.low_time = 1'b0;
    assign tif.blink    = 1'b0;
`endif

endmodule

// File: tb/tb_game_timer.sv
// Directed table-driven bench for game_timer plus hand sequences for reset, latency and expiry.
module tb_game_timer;
    import game_pkg::*;

    typedef enum int unsigned { OP_FRAMES, OP_ADD, OP_FRAMES_ADD } op_e;

    typedef struct {
        op_e         op;
        logic        run;
        int unsigned n;
        logic [7:0]  bonus;
        logic [7:0]  exp_time;
        logic        exp_oot;
    } vec_t;

`ifdef GAME_TIMER_WARNING_EN
    localparam bit WARN = 1'b1;
`else
    localparam bit WARN = 1'b0;
`endif

    logic clk = 1'b0;
    logic resetN;
    always #5 clk = ~clk;

    game_timer_if tif ();

    game_timer #(
        .START_TIME     (8'h99),
        .FRAMES_PER_SEC (30),
        .LOW_THRESHOLD  (8'h10),
        .BLINK_FRAMES   (15)
    ) dut (
        .clk    (clk),
        .resetN (resetN),
        .tif    (tif)
    );

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    vec_t        vec[18];

    function automatic vec_t mk(op_e op, logic run, int unsigned n, logic [7:0] bonus,
                                logic [7:0] exp_time, logic exp_oot);
        vec_t v;
        v.op = op; v.run = run; v.n = n; v.bonus = bonus;
        v.exp_time = exp_time; v.exp_oot = exp_oot;
        return v;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Each frame: one-cycle pulse followed by one idle cycle; returns 1ns after an edge.
    task automatic frame(input logic with_add, input logic [7:0] bonus);
        tif.startOfFrame = 1'b1;
        tif.add_time     = with_add;
        tif.time_to_add  = bonus;
        @(posedge clk); #1;
        tif.startOfFrame = 1'b0;
        tif.add_time     = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic frames(input int unsigned n);
        for (int unsigned k = 0; k < n; k++) frame(1'b0, 8'h00);
    endtask

    task automatic add(input logic [7:0] bonus);
        tif.add_time    = 1'b1;
        tif.time_to_add = bonus;
        @(posedge clk); #1;
        tif.add_time    = 1'b0;
    endtask

    task automatic check_status(input string tag, input logic [7:0] exp_time, input logic exp_oot);
        check({tag, " time"}, tif.time_digits, exp_time);
        check({tag, " oot"}, {7'd0, tif.out_of_time}, {7'd0, exp_oot});
        check({tag, " low"}, {7'd0, tif.low_time},
              {7'd0, WARN && !exp_oot && (exp_time <= 8'h10)});
`ifndef GAME_TIMER_WARNING_EN
        check({tag, " blink"}, {7'd0, tif.blink}, 8'h00);
`endif
    endtask

    initial begin
        vec[0]  = mk(OP_FRAMES,     1'b1, 29,   8'h00, 8'h99, 1'b0);
        vec[1]  = mk(OP_FRAMES,     1'b1, 1,    8'h00, 8'h98, 1'b0);
        vec[2]  = mk(OP_FRAMES,     1'b1, 90,   8'h00, 8'h95, 1'b0);
        vec[3]  = mk(OP_ADD,        1'b1, 0,    8'h10, 8'h99, 1'b0);
        vec[4]  = mk(OP_FRAMES,     1'b1, 2670, 8'h00, 8'h10, 1'b0);
        vec[5]  = mk(OP_FRAMES,     1'b1, 30,   8'h00, 8'h09, 1'b0);
        vec[6]  = mk(OP_FRAMES,     1'b0, 100,  8'h00, 8'h09, 1'b0);
        vec[7]  = mk(OP_ADD,        1'b0, 0,    8'h05, 8'h14, 1'b0);
        vec[8]  = mk(OP_FRAMES,     1'b1, 29,   8'h00, 8'h14, 1'b0);
        vec[9]  = mk(OP_FRAMES,     1'b1, 1,    8'h00, 8'h13, 1'b0);
        vec[10] = mk(OP_ADD,        1'b1, 0,    8'h0C, 8'h22, 1'b0);
        vec[11] = mk(OP_ADD,        1'b1, 0,    8'hC3, 8'h99, 1'b0);
        vec[12] = mk(OP_FRAMES,     1'b1, 2940, 8'h00, 8'h01, 1'b0);
        vec[13] = mk(OP_FRAMES_ADD, 1'b1, 30,   8'h10, 8'h10, 1'b0);
        vec[14] = mk(OP_FRAMES,     1'b1, 270,  8'h00, 8'h01, 1'b0);
        vec[15] = mk(OP_FRAMES,     1'b1, 30,   8'h00, 8'h00, 1'b1);
        vec[16] = mk(OP_ADD,        1'b1, 0,    8'h10, 8'h00, 1'b1);
        vec[17] = mk(OP_FRAMES,     1'b1, 60,   8'h00, 8'h00, 1'b1);

        resetN           = 1'b0;
        tif.startOfFrame = 1'b0;
        tif.run          = 1'b1;
        tif.add_time     = 1'b0;
        tif.time_to_add  = 8'h00;
        @(posedge clk); #1;
        check_status("reset", 8'h99, 1'b0);
        check("reset blink", {7'd0, tif.blink}, 8'h00);
        resetN = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 18; i++) begin
            tif.run = vec[i].run;
            case (vec[i].op)
                OP_FRAMES: frames(vec[i].n);
                OP_ADD:    add(vec[i].bonus);
                OP_FRAMES_ADD: begin
                    frames(vec[i].n - 1);
                    frame(1'b1, vec[i].bonus);
                end
            endcase
            check_status($sformatf("vec%0d", i), vec[i].exp_time, vec[i].exp_oot);
        end

        // Asynchronous reset out of EXPIRED, then an add on the first edge after release.
        @(posedge clk); #3;
        resetN = 1'b0;
        #1;
        check("async time", tif.time_digits, 8'h99);
        check("async oot", {7'd0, tif.out_of_time}, 8'h00);
        tif.add_time    = 1'b1;
        tif.time_to_add = 8'h05;
        @(posedge clk); #3;
        resetN = 1'b1;
        @(posedge clk); #1;
        tif.add_time = 1'b0;
        check_status("first-edge add", 8'h99, 1'b0);

        // Exact latency of the first tick, then full run to expiry.
        tif.run = 1'b1;
        frames(29);
        tif.startOfFrame = 1'b1;
        @(negedge clk);
        check("pre-tick time", tif.time_digits, 8'h99);
        @(posedge clk); #1;
        tif.startOfFrame = 1'b0;
        check_status("tick edge", 8'h98, 1'b0);
        @(posedge clk); #1;
        frames(2939);
        check_status("pulse 2969", 8'h01, 1'b0);
        frames(1);
        check_status("pulse 2970", 8'h00, 1'b1);

`ifdef GAME_TIMER_WARNING_EN
        @(posedge clk); #3;
        resetN = 1'b0;
        @(posedge clk); #3;
        resetN = 1'b1;
        @(posedge clk); #1;
        frames(2640);
        check_status("warn 11", 8'h11, 1'b0);
        frames(30);
        check_status("warn 10", 8'h10, 1'b0);
        check("warn blink0", {7'd0, tif.blink}, 8'h00);
        frames(14);
        check("warn blink14", {7'd0, tif.blink}, 8'h00);
        frames(1);
        check("warn blink15", {7'd0, tif.blink}, 8'h01);
        add(8'h20);
        check_status("warn add", 8'h30, 1'b0);
        check("warn blink off", {7'd0, tif.blink}, 8'h00);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
